// File: rtl/write_pointer_handler.sv
// Write-domain pointer and flag logic of an asynchronous FIFO: binary/Gray write pointers,
// full, almost_full, fill level and a sticky overflow flag.
module write_pointer_handler #(
  parameter int unsigned PTRWIDTH  = 3,
  parameter int unsigned AF_THRESH = 6
) (
  input  logic                wrclk,
  input  logic                write_reset_n,
  input  logic                w_en,
  input  logic [PTRWIDTH:0]   g_rptr_sync,
  input  logic                clr_overflow,
  output logic [PTRWIDTH:0]   b_wr_ptr,
  output logic [PTRWIDTH:0]   g_wr_ptr,
  output logic                w_accept,
  output logic                full,
  output logic                almost_full,
  output logic [PTRWIDTH:0]   wr_level,
  output logic                overflow
);

  localparam logic [PTRWIDTH:0] AfThresh = (PTRWIDTH + 1)'(AF_THRESH);

  logic [PTRWIDTH:0] b_next;
  logic [PTRWIDTH:0] g_next;
  logic [PTRWIDTH:0] b_rptr_sync;
  logic [PTRWIDTH:0] level_next;
  logic              full_next;

  assign w_accept = w_en & ~full;
  assign b_next   = b_wr_ptr + {{PTRWIDTH{1'b0}}, w_accept};
  assign g_next   = b_next ^ (b_next >> 1);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at and above it.
  always_comb begin
    b_rptr_sync = '0;
    for (int unsigned i = 0; i <= PTRWIDTH; i++) begin
      b_rptr_sync[i] = ^(g_rptr_sync >> i);
    end
  end

  assign level_next = b_next - b_rptr_sync;

  // Full when the write pointer is exactly one lap ahead: Gray MSB and MSB-1 both inverted.
  assign full_next = (g_next == {~g_rptr_sync[PTRWIDTH:PTRWIDTH-1],
                                 g_rptr_sync[PTRWIDTH-2:0]});

  always_ff @(posedge wrclk or negedge write_reset_n) begin
    if (!write_reset_n) begin
      b_wr_ptr    <= '0;
      g_wr_ptr    <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      b_wr_ptr    <= b_next;
      g_wr_ptr    <= g_next;
      full        <= full_next;
      almost_full <= (level_next >= AfThresh);
      wr_level    <= level_next;
      // A rejected write takes priority over a simultaneous clear.
      if (w_en && full) begin
        overflow <= 1'b1;
      end else if (clr_overflow) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule
